// File: rtl/sequence_player.sv
// Pattern generator and playback stage for the memory game.
// A new game (start) or a passed round (advance) appends one pseudo-random
// step, then the whole stored sequence is shown on four one-hot LEDs.
// A one-cycle done pulse hands control back to the player-input checker,
// which reads the stored steps through the combinational rd_addr/rd_data port.
module sequence_player #(
   parameter int         MAX_LEN    = 16,
   parameter int         ON_CYCLES  = 25000000,
   parameter int         OFF_CYCLES = 12500000,
   parameter logic [7:0] SEED       = 8'h01
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic                       advance,
   input  logic [$clog2(MAX_LEN)-1:0] rd_addr,
   output logic [1:0]                 rd_data,
   output logic [3:0]                 led,
   output logic                       busy,
   output logic                       done,
   output logic [$clog2(MAX_LEN):0]   seq_len,
   output logic                       full
);

   localparam int AW       = $clog2(MAX_LEN);
   localparam int TMAX     = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
   localparam int TW       = $clog2(TMAX + 1);
   localparam logic [AW:0]   ONE_LEN  = (AW+1)'(1);
   localparam logic [AW:0]   FULL_LEN = (AW+1)'(MAX_LEN);
   localparam logic [TW-1:0] ON_LAST  = TW'(ON_CYCLES - 1);
   localparam logic [TW-1:0] OFF_LAST = TW'(OFF_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE,
      GEN,
      ON,
      OFF,
      DONE
   } stateT;

   stateT         state;
   stateT         nextState;
   logic [1:0]    mem [MAX_LEN];
   logic [AW-1:0] idx;
   logic [AW:0]   seqLen;
   logic [TW-1:0] timer;
   logic [7:0]    lfsr;
   logic          feedback;
   logic          isFull;
   logic          onDone;
   logic          offDone;
   logic          lastStep;
   logic [3:0]    ledNext;
   logic          busyNext;
   logic          doneNext;

   assign feedback = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
   assign isFull   = (seqLen == FULL_LEN);
   assign onDone   = (timer == ON_LAST);
   assign offDone  = (timer == OFF_LAST);
   assign lastStep = ({1'b0, idx} == (seqLen - ONE_LEN));

   assign full    = isFull;
   assign seq_len = seqLen;
   assign rd_data = mem[rd_addr];

   // State register for the playback sequencer.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state decode plus the Moore output values that get registered below;
   // start beats advance, and advance only counts on a non-empty, non-full game.
   always_comb begin
      nextState = state;
      ledNext   = 4'b0000;
      busyNext  = 1'b1;
      doneNext  = 1'b0;
      case (state)
         IDLE: begin
            busyNext = 1'b0;
            if (start) begin
               nextState = GEN;
            end else if (advance && (seqLen != '0) && !isFull) begin
               nextState = GEN;
            end
         end
         GEN: begin
            nextState = ON;
         end
         ON: begin
            ledNext = 4'b0001 << mem[idx];
            if (onDone) begin
               nextState = OFF;
            end
         end
         OFF: begin
            if (offDone) begin
               nextState = lastStep ? DONE : ON;
            end
         end
         DONE: begin
            doneNext  = 1'b1;
            nextState = IDLE;
         end
         default: begin
            busyNext  = 1'b0;
            nextState = IDLE;
         end
      endcase
   end

   // Sequence length, playback index, step timer and the free-running LFSR.
   always_ff @(posedge clk) begin
      if (reset) begin
         seqLen <= '0;
         idx    <= '0;
         timer  <= '0;
         lfsr   <= SEED;
      end else begin
         lfsr <= {lfsr[6:0], feedback};
         case (state)
            IDLE: begin
               if (start) begin
                  seqLen <= '0;
               end
            end
            GEN: begin
               seqLen <= seqLen + ONE_LEN;
               idx    <= '0;
               timer  <= '0;
            end
            ON: begin
               timer <= onDone ? '0 : timer + TW'(1);
            end
            OFF: begin
               if (offDone) begin
                  timer <= '0;
                  if (!lastStep) begin
                     idx <= idx + AW'(1);
                  end
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            default: begin
               timer <= '0;
            end
         endcase
      end
   end

   // Step storage: GEN writes the new step at the current end of the sequence.
   always_ff @(posedge clk) begin
      if (!reset && (state == GEN)) begin
         mem[seqLen[AW-1:0]] <= lfsr[1:0];
      end
   end

   // Registered LED/busy/done outputs, one clock behind the state they describe.
   always_ff @(posedge clk) begin
      if (reset) begin
         led  <= 4'b0000;
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         led  <= ledNext;
         busy <= busyNext;
         done <= doneNext;
      end
   end

endmodule
